// File: rtl/control_unit_64.sv
// control_unit_64 -- multicycle control FSM for the 64-bit RV64I-subset datapath.
//
// Sequences fetch/decode/execute/memory/writeback, drives the datapath selects,
// handshakes with memory through mem_ready, counts retired instructions and
// traps (sticky) on illegal opcodes, unsupported branch funct3 or memory timeout.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   opcode, funct3        fields of instr_all from instr_reg_64
//   alu_zero              ALU zero flag, used in BRANCH
//   mem_ready             memory completes the current access this cycle
//   load_ir, pc_write     instruction-register load, PC write enable
//   pc_src                0=ALU result, 1=ALUOut
//   mem_read, mem_write   memory requests, held until mem_ready
//   iord                  0=PC address, 1=ALUOut address
//   reg_write, mem_to_reg register-file write enable, 0=ALUOut 1=MDR 2=PC
//   alu_src_a, alu_src_b  0=PC 1=rs1 / 0=rs2 1=const 4 2=immediate
//   alu_op                0=add 1=sub 2=funct decode 3=pass-B
//   trap, trap_cause      sticky error, 1=illegal 2=timeout 3=bad branch funct3
//   retired               instructions completed since reset (wraps)
//   state_dbg             current state encoding
//
// state    | meaning
// ---------+-------------------------------------------------
// FETCH    | read instruction at PC, PC+4 on mem_ready
// DECODE   | latch opcode, branch target into ALUOut
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// LUI      | pass immediate
// MEM_ADDR | rs1 + imm address calculation
// MEM_RD   | load access, wait for mem_ready
// MEM_WB   | MDR into register file
// MEM_WR   | store access, wait for mem_ready
// BRANCH   | compare, conditional PC write
// JAL      | PC = target, rd = PC
// ALU_WB   | ALUOut into register file
// TRAP     | error halt until reset

module control_unit_64 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             load_ir,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_LUI      = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_ALU_WB   = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Counter only needs to hold 0..TIMEOUT-1; the TIMEOUT-th idle cycle leaves the state.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [3:0]        state, state_nxt;
    logic [6:0]        opcode_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic [1:0]        cause_nxt;
    logic              timeout_hit;
    logic              mem_state;
    logic              wait_clear;
    logic              trap_q;
    logic [1:0]        cause_q;

    assign mem_state   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout_hit = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
    assign wait_clear  = (state_nxt != state) &&
                         ((state_nxt == S_FETCH) || (state_nxt == S_MEM_RD) || (state_nxt == S_MEM_WR));

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        cause_nxt = 2'd0;
        case (state)
            S_FETCH: begin
                if (mem_ready)        state_nxt = S_DECODE;
                else if (timeout_hit) begin state_nxt = S_TRAP; cause_nxt = 2'd2; end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_nxt = S_EXEC_R;
                    OP_I:               state_nxt = S_EXEC_I;
                    OP_LUI:             state_nxt = S_LUI;
                    OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
                    OP_BRANCH:          state_nxt = S_BRANCH;
                    OP_JAL:             state_nxt = S_JAL;
                    default: begin state_nxt = S_TRAP; cause_nxt = 2'd1; end
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI: state_nxt = S_ALU_WB;
            S_MEM_ADDR: state_nxt = (opcode_q == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)        state_nxt = S_MEM_WB;
                else if (timeout_hit) begin state_nxt = S_TRAP; cause_nxt = 2'd2; end
            end
            S_MEM_WR: begin
                if (mem_ready)        begin state_nxt = S_FETCH; retire = 1'b1; end
                else if (timeout_hit) begin state_nxt = S_TRAP; cause_nxt = 2'd2; end
            end
            S_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end else begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'd3;
                end
            end
            S_MEM_WB, S_JAL, S_ALU_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            opcode_q <= 7'd0;
            wait_cnt <= '0;
            retired  <= '0;
            trap_q   <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) opcode_q <= opcode;
            if (wait_clear)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready && !timeout_hit)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (retire) retired <= retired + CNT_W'(1);
            if (state_nxt == S_TRAP && state != S_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= cause_nxt;
            end
        end
    end

    // Enables and requests are gated while reset is held so an abandoned access
    // never shows a request in the cycles that reset is asserted.
    always_comb begin
        load_ir    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        case (state)
            S_FETCH: begin
                mem_read  = !reset;
                alu_src_b = 2'd1;
                load_ir   = mem_ready && !reset;
                pc_write  = mem_ready && !reset;
            end
            S_DECODE:   alu_src_b = 2'd2;
            S_EXEC_R:   begin alu_src_a = 1'b1; alu_op = 2'd2; end
            S_EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = 2'd2; end
            S_LUI:      begin alu_src_b = 2'd2; alu_op = 2'd3; end
            S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
            S_MEM_RD:   begin mem_read = !reset; iord = 1'b1; end
            S_MEM_WB:   begin reg_write = !reset; mem_to_reg = 2'd1; end
            S_MEM_WR:   begin mem_write = !reset; iord = 1'b1; end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                if (!reset) begin
                    if (funct3 == 3'b000)      pc_write = alu_zero;
                    else if (funct3 == 3'b001) pc_write = !alu_zero;
                end
            end
            S_JAL: begin
                pc_write   = !reset;
                pc_src     = 2'd1;
                reg_write  = !reset;
                mem_to_reg = 2'd2;
            end
            S_ALU_WB:   reg_write = !reset;
            default: ;
        endcase
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_control_unit_64.sv
module tb_control_unit_64;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                           LUI = 4'd4, MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WB = 4'd7,
                           MEM_WR = 4'd8, BRANCH = 4'd9, JAL = 4'd10, ALU_WB = 4'd11,
                           TRAP = 4'd12;

    typedef struct packed {
        logic       li, pw;
        logic [1:0] pc_src;
        logic       mr, mw, iord, rw;
        logic [1:0] m2r;
        logic       sa;
        logic [1:0] sb, op;
        logic       trap;
        logic [1:0] cause;
    } ctl_t;

    typedef struct {
        string            tag;
        logic [3:0]       st;
        ctl_t             ctl;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic alu_zero = 1'b0;
    logic mem_ready = 1'b0;
    logic load_ir, pc_write, mem_read, mem_write, iord, reg_write, alu_src_a, trap;
    logic [1:0] pc_src, mem_to_reg, alu_src_b, alu_op, trap_cause;
    logic [CNT_W-1:0] retired;
    logic [3:0] state_dbg;

    control_unit_64 #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .load_ir(load_ir), .pc_write(pc_write), .pc_src(pc_src),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause), .retired(retired),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    exp_t             sb_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    // Expected Moore outputs of each state, written from the state descriptions.
    function automatic ctl_t base(input logic [3:0] st, input logic [1:0] cause);
        ctl_t c = '0;
        case (st)
            FETCH:    begin c.mr = 1; c.sb = 2'd1; end
            DECODE:   c.sb = 2'd2;
            EXEC_R:   begin c.sa = 1; c.op = 2'd2; end
            EXEC_I:   begin c.sa = 1; c.sb = 2'd2; c.op = 2'd2; end
            LUI:      begin c.sb = 2'd2; c.op = 2'd3; end
            MEM_ADDR: begin c.sa = 1; c.sb = 2'd2; end
            MEM_RD:   begin c.mr = 1; c.iord = 1; end
            MEM_WB:   begin c.rw = 1; c.m2r = 2'd1; end
            MEM_WR:   begin c.mw = 1; c.iord = 1; end
            BRANCH:   begin c.sa = 1; c.op = 2'd1; c.pc_src = 2'd1; end
            JAL:      begin c.pw = 1; c.pc_src = 2'd1; c.rw = 1; c.m2r = 2'd2; end
            ALU_WB:   c.rw = 1;
            TRAP:     begin c.trap = 1; c.cause = cause; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // One clock of stimulus: drive inputs, queue what this cycle must show.
    task automatic cyc(input string tag, input logic rdy, input logic az, input logic [3:0] st,
                       input logic li, input logic pw, input logic [1:0] cause);
        exp_t e;
        mem_ready = rdy;
        alu_zero  = az;
        e.tag = tag;
        e.st  = st;
        e.ctl = base(st, cause);
        e.ctl.li = li;
        e.ctl.pw = e.ctl.pw | pw;
        e.ret = exp_ret;
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        exp_ret = '0;
        e.tag = tag;
        e.st  = FETCH;
        e.ctl = base(FETCH, 2'd0);
        e.ctl.mr = 1'b0;
        e.ret = '0;
        sb_q.push_back(e);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_alu(input string tag, input logic [6:0] opc, input logic [3:0] ex);
        opcode = opc;
        cyc({tag, "_fetch"}, 1, 0, FETCH, 1, 1, 0);
        cyc({tag, "_decode"}, 1, 0, DECODE, 0, 0, 0);
        cyc({tag, "_exec"}, 1, 0, ex, 0, 0, 0);
        cyc({tag, "_wb"}, 1, 0, ALU_WB, 0, 0, 0);
        exp_ret++;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            ctl_t act;
            e = sb_q.pop_front();
            act = {load_ir, pc_write, pc_src, mem_read, mem_write, iord, reg_write,
                   mem_to_reg, alu_src_a, alu_src_b, alu_op, trap, trap_cause};
            n_tests++;
            if (state_dbg !== e.st || act !== e.ctl || retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s: got state=%0d ctl=%05h retired=%0d, want state=%0d ctl=%05h retired=%0d",
                         e.tag, state_dbg, act, retired, e.st, e.ctl, e.ret);
            end
            if (mem_read && mem_write) begin
                n_fail++;
                $display("FAIL %s_req_excl: got mem_read=1 mem_write=1, want not both", e.tag);
            end
        end
    end

    initial begin
        do_reset("reset");

        // ADD with memory always ready
        run_alu("add", 7'b0110011, EXEC_R);

        // LW with three wait cycles in MEM_RD
        opcode = 7'b0000011;
        cyc("lw_fetch", 1, 0, FETCH, 1, 1, 0);
        cyc("lw_decode", 1, 0, DECODE, 0, 0, 0);
        opcode = 7'b0110011;   // live opcode changes; latched copy must steer MEM_ADDR
        cyc("lw_addr", 0, 0, MEM_ADDR, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("lw_wait", 0, 0, MEM_RD, 0, 0, 0);
        cyc("lw_rd_done", 1, 0, MEM_RD, 0, 0, 0);
        cyc("lw_wb", 0, 0, MEM_WB, 0, 0, 0);
        exp_ret++;

        // SW, ADDI, LUI, JAL
        opcode = 7'b0100011;
        cyc("sw_fetch", 1, 0, FETCH, 1, 1, 0);
        cyc("sw_decode", 1, 0, DECODE, 0, 0, 0);
        cyc("sw_addr", 1, 0, MEM_ADDR, 0, 0, 0);
        cyc("sw_wr", 1, 0, MEM_WR, 0, 0, 0);
        exp_ret++;
        run_alu("addi", 7'b0010011, EXEC_I);
        run_alu("lui", 7'b0110111, LUI);
        opcode = 7'b1101111;
        cyc("jal_fetch", 1, 0, FETCH, 1, 1, 0);
        cyc("jal_decode", 1, 0, DECODE, 0, 0, 0);
        cyc("jal_exec", 1, 0, JAL, 0, 1, 0);
        exp_ret++;

        // BEQ taken, BNE not taken (alu_zero=1 in both)
        opcode = 7'b1100011; funct3 = 3'b000;
        cyc("beq_fetch", 1, 1, FETCH, 1, 1, 0);
        cyc("beq_decode", 1, 1, DECODE, 0, 0, 0);
        cyc("beq_branch", 1, 1, BRANCH, 0, 1, 0);
        exp_ret++;
        funct3 = 3'b001;
        cyc("bne_fetch", 1, 1, FETCH, 1, 1, 0);
        cyc("bne_decode", 1, 1, DECODE, 0, 0, 0);
        cyc("bne_branch", 1, 1, BRANCH, 0, 0, 0);
        exp_ret++;

        // Illegal opcode, trap is sticky and ignores mem_ready
        opcode = 7'b1111111; funct3 = 3'b000;
        cyc("ill_fetch", 1, 0, FETCH, 1, 1, 0);
        cyc("ill_decode", 1, 0, DECODE, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc("ill_trap", i[0], 0, TRAP, 0, 0, 2'd1);
        do_reset("ill_reset");

        // Fetch timeout: TIMEOUT idle cycles trap
        for (int i = 0; i < TIMEOUT; i++) cyc("to_fetch_wait", 0, 0, FETCH, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("to_trap", 1, 0, TRAP, 0, 0, 2'd2);
        do_reset("to_reset");

        // Ready on exactly the TIMEOUT-th cycle completes normally
        opcode = 7'b0110011;
        for (int i = 0; i < TIMEOUT - 1; i++) cyc("edge_fetch_wait", 0, 0, FETCH, 0, 0, 0);
        cyc("edge_fetch_done", 1, 0, FETCH, 1, 1, 0);
        cyc("edge_decode", 1, 0, DECODE, 0, 0, 0);
        cyc("edge_exec", 1, 0, EXEC_R, 0, 0, 0);
        cyc("edge_wb", 1, 0, ALU_WB, 0, 0, 0);
        exp_ret++;

        // Store timeout in MEM_WR
        opcode = 7'b0100011;
        cyc("swto_fetch", 1, 0, FETCH, 1, 1, 0);
        cyc("swto_decode", 1, 0, DECODE, 0, 0, 0);
        cyc("swto_addr", 0, 0, MEM_ADDR, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) cyc("swto_wait", 0, 0, MEM_WR, 0, 0, 0);
        cyc("swto_trap", 0, 0, TRAP, 0, 0, 2'd2);
        do_reset("swto_reset");

        // Unsupported branch funct3
        opcode = 7'b1100011; funct3 = 3'b010;
        cyc("bx_fetch", 1, 0, FETCH, 1, 1, 0);
        cyc("bx_decode", 1, 0, DECODE, 0, 0, 0);
        cyc("bx_branch", 1, 0, BRANCH, 0, 0, 0);
        cyc("bx_trap", 1, 0, TRAP, 0, 0, 2'd3);
        funct3 = 3'b000;
        do_reset("bx_reset");

        // Counter wrap on the 4-bit build: 15 -> 0 -> 1
        for (int i = 0; i < 17; i++) run_alu("wrap_add", 7'b0110011, EXEC_R);

        // Reset while a store is waiting in MEM_WR
        opcode = 7'b0100011;
        cyc("swr_fetch", 1, 0, FETCH, 1, 1, 0);
        cyc("swr_decode", 0, 0, DECODE, 0, 0, 0);
        cyc("swr_addr", 0, 0, MEM_ADDR, 0, 0, 0);
        cyc("swr_wait", 0, 0, MEM_WR, 0, 0, 0);
        do_reset("swr_reset");
        cyc("swr_after", 0, 0, FETCH, 0, 0, 0);

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending checks, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
